// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush control logic.
//   - Sequencer state encoding (RUN / LU_STALL / MEM_WAIT).
//   - Zero-register constant used by hazard compares.
//   - Packed control-word type plus the canonical control words the
//     sequencer drives (idle, load-use bubble, frozen, branch, jump, reset).
// Optional feature macro used elsewhere: HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_LU_STALL = 2'd1;
    localparam state_t ST_MEM_WAIT = 2'd2;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Bit order matches the output port order of the sequencer.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ctrl_zero;
        logic if_flush;
        logic id_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = 7'b1111_0_00;
    localparam ctrl_t CTRL_LU     = 7'b0011_1_00;
    localparam ctrl_t CTRL_FROZEN = 7'b0000_0_00;
    localparam ctrl_t CTRL_BRANCH = 7'b1111_0_11;
    localparam ctrl_t CTRL_JUMP   = 7'b1111_0_10;
    localparam ctrl_t CTRL_RESET  = 7'b0000_1_00;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare: the instruction in ID reads a
// register that the load currently in EX has not yet produced. Loads into
// $zero never create a hazard.
// Ports:
//   ID_rs, ID_rt   in  5  source registers of the ID instruction
//   EXE_rt         in  5  destination register of the EX instruction
//   EXE_MemRead    in  1  EX instruction is a load
//   lu_hz          out 1  load-use hazard present
// -----------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module load_use_detect (
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [4:0] EXE_rt,
    input  logic       EXE_MemRead,
    output logic       lu_hz
);

    // Hazard compare against the pending load destination.
    always_comb begin
        lu_hz = EXE_MemRead & (EXE_rt != ZERO_REG) &
                ((ID_rs == EXE_rt) | (ID_rt == EXE_rt));
    end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_stall_sequencer
// Prioritised stall/flush controller for the 5-stage MIPS pipeline.
// Priority per cycle: mem stall > EX branch flush > load-use > ID jump/jr.
// Outputs are Mealy (registered state + current inputs); while rst is low the
// outputs are forced to the reset control word immediately.
// Parameters: LU_STALL_CYC (1..3), MEM_TIMEOUT (>=1), CNT_W (counter width).
// Ports:
//   clk, rst (async, active-low)
//   ID_rs, ID_rt, EXE_rt, EXE_MemRead       load-use hazard inputs
//   EX_branch_taken, ID_jump, ID_jr         control-flow change inputs
//   dmem_req, dmem_ready                    data-memory handshake
//   PCwrite, IFID_write, IDEX_write, EXMEM_write  stage enables
//   control_mux_sel                         1 = bubble the ID control word
//   IF_flush, ID_flush                      clear IF/ID, ID/EX
//   mem_err                                 sticky memory-timeout flag
//   stall_cycles, flush_events              only with HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module pipeline_stall_sequencer #(
    parameter int LU_STALL_CYC = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  EXE_rt,
    input  logic        EXE_MemRead,
    input  logic        EX_branch_taken,
    input  logic        ID_jump,
    input  logic        ID_jr,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        PCwrite,
    output logic        IFID_write,
    output logic        IDEX_write,
    output logic        EXMEM_write,
    output logic        control_mux_sel,
    output logic        IF_flush,
    output logic        ID_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic        mem_err
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MEM_RELOAD = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LU_RELOAD  =
        CNT_W'((LU_STALL_CYC > 1) ? (LU_STALL_CYC - 2) : 0);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             mem_err_r, err_set_s;
    logic             lu_hz_s, mem_stall_s, mem_release_s;
    ctrl_t            ctrl_s;

    load_use_detect u_lu (
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .EXE_rt      (EXE_rt),
        .EXE_MemRead (EXE_MemRead),
        .lu_hz       (lu_hz_s)
    );

    // Memory handshake decode: stall request and MEM_WAIT exit (ready or timeout).
    always_comb begin
        mem_stall_s   = dmem_req & ~dmem_ready;
        mem_release_s = dmem_ready | (cnt_r == '0);
    end

    // State register, down-counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mem_err_r <= mem_err_r | err_set_s;
        end
    end

    // Next-state logic. A MEM_WAIT release cycle (ready or timeout) is a
    // normal RUN cycle with the memory term ignored, so a branch or load-use
    // hazard present at that moment is still honoured.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_set_s   = 1'b0;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_r == ST_RUN) && mem_stall_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                    cnt_nxt_s   = MEM_RELOAD;
                end else if ((state_r == ST_MEM_WAIT) && !mem_release_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end else begin
                    // Timeout: counter expired without ready.
                    err_set_s   = (state_r == ST_MEM_WAIT) & ~dmem_ready;
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                    if (!EX_branch_taken && lu_hz_s && (LU_STALL_CYC > 1)) begin
                        state_nxt_s = ST_LU_STALL;
                        cnt_nxt_s   = LU_RELOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_LU_STALL: begin
                if (mem_stall_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                    cnt_nxt_s   = MEM_RELOAD;
                end else if (cnt_r == '0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output decode (Mealy); reset overrides everything asynchronously.
    always_comb begin
        ctrl_s = CTRL_IDLE;
        if (!rst) begin
            ctrl_s = CTRL_RESET;
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state_r == ST_RUN) ? mem_stall_s : !mem_release_s) begin
                        ctrl_s = CTRL_FROZEN;
                    end else if (EX_branch_taken) begin
                        ctrl_s = CTRL_BRANCH;
                    end else if (lu_hz_s) begin
                        ctrl_s = CTRL_LU;
                    end else if (ID_jump | ID_jr) begin
                        ctrl_s = CTRL_JUMP;
                    end else begin
                        ctrl_s = CTRL_IDLE;
                    end
                end
                ST_LU_STALL: begin
                    if (mem_stall_s) begin
                        ctrl_s = CTRL_FROZEN;
                    end else begin
                        ctrl_s = CTRL_LU;
                    end
                end
                default: ctrl_s = CTRL_FROZEN;
            endcase
        end
    end

    // Port mapping of the control word.
    always_comb begin
        PCwrite         = ctrl_s.pc_write;
        IFID_write      = ctrl_s.ifid_write;
        IDEX_write      = ctrl_s.idex_write;
        EXMEM_write     = ctrl_s.exmem_write;
        control_mux_sel = ctrl_s.ctrl_zero;
        IF_flush        = ctrl_s.if_flush;
        ID_flush        = ctrl_s.id_flush;
        mem_err         = mem_err_r;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_r, flush_events_r;

    // Saturating stall / flush event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_r <= 32'd0;
            flush_events_r <= 32'd0;
        end else begin
            if (!ctrl_s.pc_write && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (ctrl_s.if_flush && (flush_events_r != 32'hFFFF_FFFF)) begin
                flush_events_r <= flush_events_r + 32'd1;
            end
        end
    end

    // Counter outputs.
    always_comb begin
        stall_cycles = stall_cycles_r;
        flush_events = flush_events_r;
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
`timescale 1ns/1ps
module tb_pipeline_stall_sequencer;

    // {PCwrite, IFID_write, IDEX_write, EXMEM_write, control_mux_sel, IF_flush, ID_flush}
    localparam logic [6:0] E_IDLE = 7'b1111_0_00;
    localparam logic [6:0] E_LU   = 7'b0011_1_00;
    localparam logic [6:0] E_FRZ  = 7'b0000_0_00;
    localparam logic [6:0] E_BR   = 7'b1111_0_11;
    localparam logic [6:0] E_JMP  = 7'b1111_0_10;
    localparam logic [6:0] E_RST  = 7'b0000_1_00;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EXE_rt;
    logic       EXE_MemRead, EX_branch_taken, ID_jump, ID_jr, dmem_req, dmem_ready;

    logic pcw_a, ifid_a, idex_a, exmem_a, mux_a, iff_a, idf_a, err_a;
    logic pcw_b, ifid_b, idex_b, exmem_b, mux_b, iff_b, idf_b, err_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fe_a, sc_b, fe_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_sequencer dut_a (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .EXE_rt(EXE_rt),
        .EXE_MemRead(EXE_MemRead), .EX_branch_taken(EX_branch_taken),
        .ID_jump(ID_jump), .ID_jr(ID_jr), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCwrite(pcw_a), .IFID_write(ifid_a), .IDEX_write(idex_a), .EXMEM_write(exmem_a),
        .control_mux_sel(mux_a), .IF_flush(iff_a), .ID_flush(idf_a),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc_a), .flush_events(fe_a),
`endif
        .mem_err(err_a)
    );

    pipeline_stall_sequencer #(.LU_STALL_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .EXE_rt(EXE_rt),
        .EXE_MemRead(EXE_MemRead), .EX_branch_taken(EX_branch_taken),
        .ID_jump(ID_jump), .ID_jr(ID_jr), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCwrite(pcw_b), .IFID_write(ifid_b), .IDEX_write(idex_b), .EXMEM_write(exmem_b),
        .control_mux_sel(mux_b), .IF_flush(iff_b), .ID_flush(idf_b),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc_b), .flush_events(fe_b),
`endif
        .mem_err(err_b)
    );

    wire [6:0] obs_a = {pcw_a, ifid_a, idex_a, exmem_a, mux_a, iff_a, idf_a};
    wire [6:0] obs_b = {pcw_b, ifid_b, idex_b, exmem_b, mux_b, iff_b, idf_b};

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check both DUTs at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [6:0] exp_a, input logic [6:0] exp_b,
                        input logic exp_err);
        @(negedge clk);
        chk7({tag, "/a"}, obs_a, exp_a);
        chk7({tag, "/b"}, obs_b, exp_b);
        chk1({tag, "/err_a"}, err_a, exp_err);
        chk1({tag, "/err_b"}, err_b, exp_err);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ID_rs = 5'd0; ID_rt = 5'd0; EXE_rt = 5'd0; EXE_MemRead = 1'b0;
        EX_branch_taken = 1'b0; ID_jump = 1'b0; ID_jr = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        // Reset values
        step("reset", E_RST, E_RST, 1'b0);
        rst = 1'b1;
        step("idle", E_IDLE, E_IDLE, 1'b0);

        // Load-use on rs: A stalls 1 cycle, B (LU_STALL_CYC=3) stalls 3
        EXE_MemRead = 1'b1; EXE_rt = 5'd8; ID_rs = 5'd8; ID_rt = 5'd3;
        step("lu_rs_c1", E_LU, E_LU, 1'b0);
        clear_in();
        step("lu_rs_c2", E_IDLE, E_LU, 1'b0);
        step("lu_rs_c3", E_IDLE, E_LU, 1'b0);
        step("lu_rs_c4", E_IDLE, E_IDLE, 1'b0);

        // Load-use on rt
        EXE_MemRead = 1'b1; EXE_rt = 5'd5; ID_rs = 5'd1; ID_rt = 5'd5;
        step("lu_rt_c1", E_LU, E_LU, 1'b0);
        clear_in();
        step("lu_rt_c2", E_IDLE, E_LU, 1'b0);
        step("lu_rt_c3", E_IDLE, E_LU, 1'b0);
        step("lu_rt_c4", E_IDLE, E_IDLE, 1'b0);

        // Load into $zero never stalls
        EXE_MemRead = 1'b1; EXE_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
        step("lu_zero", E_IDLE, E_IDLE, 1'b0);
        // Matching regs but not a load
        EXE_MemRead = 1'b0; EXE_rt = 5'd8; ID_rs = 5'd8;
        step("no_load", E_IDLE, E_IDLE, 1'b0);
        clear_in();

        // Plain jump
        ID_jump = 1'b1;
        step("jump", E_JMP, E_JMP, 1'b0);
        clear_in();

        // Access completing in the same cycle: no stall
        dmem_req = 1'b1; dmem_ready = 1'b1;
        step("mem_fast", E_IDLE, E_IDLE, 1'b0);

        // Ready low for 4 cycles, released on the ready cycle
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("mem_wait", E_FRZ, E_FRZ, 1'b0);
        dmem_ready = 1'b1;
        step("mem_ready", E_IDLE, E_IDLE, 1'b0);
        clear_in();
        step("mem_after", E_IDLE, E_IDLE, 1'b0);

        // Mem stall beats a taken branch
        dmem_req = 1'b1; EX_branch_taken = 1'b1;
        step("mem_vs_br", E_FRZ, E_FRZ, 1'b0);
        EX_branch_taken = 1'b0; dmem_ready = 1'b1;
        step("mem_vs_br_rel", E_IDLE, E_IDLE, 1'b0);
        clear_in();

        // Timeout: 15 frozen cycles, forced resume, sticky mem_err
        dmem_req = 1'b1;
        for (int i = 0; i < 15; i++) step("timeout_frz", E_FRZ, E_FRZ, 1'b0);
        step("timeout_resume", E_IDLE, E_IDLE, 1'b0);
        clear_in();
        step("timeout_err", E_IDLE, E_IDLE, 1'b1);
        step("timeout_sticky", E_IDLE, E_IDLE, 1'b1);

        // Branch together with load-use: flush, no stall
        EXE_MemRead = 1'b1; EXE_rt = 5'd8; ID_rs = 5'd8; EX_branch_taken = 1'b1;
        step("br_lu", E_BR, E_BR, 1'b1);
        clear_in();
        step("br_lu_after", E_IDLE, E_IDLE, 1'b1);

        // jr with load-use on rs: stall first, then flush
        EXE_MemRead = 1'b1; EXE_rt = 5'd8; ID_rs = 5'd8; ID_jr = 1'b1;
        step("jr_lu_c1", E_LU, E_LU, 1'b1);
        EXE_MemRead = 1'b0; EXE_rt = 5'd0;
        step("jr_lu_c2", E_JMP, E_LU, 1'b1);
        ID_jr = 1'b0;
        step("jr_lu_c3", E_IDLE, E_LU, 1'b1);
        clear_in();
        step("jr_lu_c4", E_IDLE, E_IDLE, 1'b1);

        // Reset asserted mid MEM_WAIT
        dmem_req = 1'b1;
        step("rst_mw_c1", E_FRZ, E_FRZ, 1'b1);
        step("rst_mw_c2", E_FRZ, E_FRZ, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk7("rst_async/a", obs_a, E_RST);
        chk7("rst_async/b", obs_b, E_RST);
        chk1("rst_async/err_a", err_a, 1'b0);
        chk1("rst_async/err_b", err_b, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk7("rst_perf_sc", sc_a[6:0], 7'd0);
        chk7("rst_perf_fe", fe_a[6:0], 7'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_in();
        step("rst_release", E_IDLE, E_IDLE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
